// File: rtl/hilo_pkg.sv
// hilo_pkg: request codes, FSM states and accumulator commands shared by the HI/LO controller.
package hilo_pkg;

    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_MADD = 3'd2;
    localparam logic [2:0] OP_MSUB = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    localparam logic [1:0] MUL_OP_MULT = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    typedef enum logic [2:0] {
        ACC_NONE,
        ACC_SET,
        ACC_ADD,
        ACC_SUB,
        ACC_HI,
        ACC_LO
    } acc_cmd_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return op == OP_MULT || op == OP_MADD || op == OP_MSUB;
    endfunction

endpackage

// File: rtl/hilo_acc.sv
// hilo_acc: 64-bit HI:LO register with overwrite, add, subtract and move-to-half updates.
module hilo_acc
    import hilo_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  cmd,
    input  logic [63:0] prod,
    input  logic [31:0] src,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] acc;
    logic [63:0] acc_nxt;

    // Add/subtract wrap mod 2^64; signedness was already applied to the product.
    always_comb begin
        acc_nxt = cmd == ACC_SET ? prod :
                  cmd == ACC_ADD ? acc + prod :
                  cmd == ACC_SUB ? acc - prod :
                  cmd == ACC_HI  ? {src, acc[31:0]} :
                  cmd == ACC_LO  ? {acc[63:32], src} : acc;
    end

    always_ff @(posedge clock) begin
        if (reset)
            acc <= '0;
        else
            acc <= acc_nxt;
    end

    assign hi = acc[63:32];
    assign lo = acc[31:0];

endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: CPU-facing HI/LO unit; issues multiplies downstream and folds results into HI:LO.
module hilo_ctrl
    import hilo_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic        req_sign,
    input  logic [31:0] req_src0,
    input  logic [31:0] req_src1,
    output logic        req_ready,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mul_in_src0,
    output logic [31:0] mul_in_src1,
    output logic [1:0]  mul_in_op,
    output logic        mul_in_sign,
    output logic        mul_in_valid,
    input  logic        mul_in_ready,
    input  logic        mul_out_valid,
    output logic        mul_out_ready,
    input  logic [31:0] mul_out_res0,
    input  logic [31:0] mul_out_res1
);

    state_t     state;
    logic [2:0] op_q;
    logic [2:0] acc_cmd;
    logic       accept;
    logic       done;

    assign req_ready = state == ST_IDLE;
    assign busy      = state != ST_IDLE;
    assign mul_in_op = MUL_OP_MULT;
    assign accept    = req_valid & req_ready;
    assign done      = mul_out_valid & mul_out_ready;

    // mul_out_ready is only high in WAIT, so a stray result elsewhere never reaches HI:LO.
    always_comb begin
        acc_cmd = done    ? (op_q == OP_MULT ? ACC_SET : op_q == OP_MADD ? ACC_ADD : ACC_SUB) :
                  !accept ? ACC_NONE :
                  req_op == OP_MTHI ? ACC_HI :
                  req_op == OP_MTLO ? ACC_LO : ACC_NONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            op_q          <= '0;
            mul_in_src0   <= '0;
            mul_in_src1   <= '0;
            mul_in_sign   <= 1'b0;
            mul_in_valid  <= 1'b0;
            mul_out_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && is_mul_op(req_op)) begin
                        op_q         <= req_op;
                        mul_in_src0  <= req_src0;
                        mul_in_src1  <= req_src1;
                        mul_in_sign  <= req_sign;
                        mul_in_valid <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mul_in_ready) begin
                        mul_in_valid  <= 1'b0;
                        mul_out_ready <= 1'b1;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mul_out_valid) begin
                        mul_out_ready <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    hilo_acc u_acc (
        .clock (clock),
        .reset (reset),
        .cmd   (acc_cmd),
        .prod  ({mul_out_res1, mul_out_res0}),
        .src   (req_src0),
        .hi    (hi),
        .lo    (lo)
    );

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed vectors for hilo_ctrl against a behavioural multiplier with stall controls.
module tb_hilo_ctrl;
    import hilo_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic        req_sign = 1'b0;
    logic [31:0] req_src0 = '0;
    logic [31:0] req_src1 = '0;
    logic        req_ready, busy;
    logic [31:0] hi, lo, mul_in_src0, mul_in_src1;
    logic [1:0]  mul_in_op;
    logic        mul_in_sign, mul_in_valid, mul_in_ready;
    logic        mul_out_valid, mul_out_ready;
    logic [31:0] mul_out_res0, mul_out_res1;

    int n_tests = 0;
    int n_fail  = 0;
    int c;

    logic        in_rdy_en = 1'b1;
    logic        spurious  = 1'b0;
    int          out_delay = 0;
    logic        pend;
    int          cnt;
    logic [63:0] prod;

    always #5 clock = ~clock;

    hilo_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_sign      (req_sign),
        .req_src0      (req_src0),
        .req_src1      (req_src1),
        .req_ready     (req_ready),
        .busy          (busy),
        .hi            (hi),
        .lo            (lo),
        .mul_in_src0   (mul_in_src0),
        .mul_in_src1   (mul_in_src1),
        .mul_in_op     (mul_in_op),
        .mul_in_sign   (mul_in_sign),
        .mul_in_valid  (mul_in_valid),
        .mul_in_ready  (mul_in_ready),
        .mul_out_valid (mul_out_valid),
        .mul_out_ready (mul_out_ready),
        .mul_out_res0  (mul_out_res0),
        .mul_out_res1  (mul_out_res1)
    );

    // Downstream multiplier: result appears out_delay cycles after entering WAIT.
    assign mul_in_ready  = in_rdy_en;
    assign mul_out_valid = (pend && cnt == 0) || spurious;
    assign mul_out_res0  = spurious ? 32'hDEADBEEF : prod[31:0];
    assign mul_out_res1  = spurious ? 32'hCAFEF00D : prod[63:32];

    always @(posedge clock) begin
        if (reset) begin
            pend <= 1'b0;
            cnt  <= 0;
            prod <= '0;
        end else if (mul_in_valid && mul_in_ready) begin
            pend <= 1'b1;
            cnt  <= out_delay;
            prod <= mul_in_sign ? {{32{mul_in_src0[31]}}, mul_in_src0} * {{32{mul_in_src1[31]}}, mul_in_src1}
                                : {32'b0, mul_in_src0} * {32'b0, mul_in_src1};
        end else if (pend && cnt > 0) begin
            cnt <= cnt - 1;
        end else if (mul_out_valid && mul_out_ready) begin
            pend <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns one negedge after the accepting edge, with req_valid dropped.
    task automatic req(input logic [2:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = op;
        req_sign  = sg;
        req_src0  = a;
        req_src1  = b;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clock);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        check("rst_in_valid", mul_in_valid, 0);
        check("rst_out_ready", mul_out_ready, 0);
        check("rst_src0", mul_in_src0, 0);
        check("mul_op", mul_in_op, 1);

        out_delay = 1;
        req(OP_MULT, 1'b1, 32'hFFFFFFFF, 32'h2);
        wait_idle(c);
        check("smul_busy_cycles", c, 3);
        check("smul_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);

        out_delay = 0;
        req(OP_MULT, 1'b0, 32'hFFFFFFFF, 32'h2);
        check("lat_issue_valid", mul_in_valid, 1);
        check("lat_issue_src1", mul_in_src1, 2);
        check("lat_issue_sign", mul_in_sign, 0);
        @(negedge clock);
        check("lat_wait_ready", mul_out_ready, 1);
        check("lat_wait_in_valid", mul_in_valid, 0);
        check("lat_wait_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
        @(negedge clock);
        check("lat_done_busy", busy, 0);
        check("umul_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);

        req(OP_MTHI, 1'b0, 32'h0, 32'h0);
        check("mthi_busy", busy, 0);
        check("mthi_hilo", {hi, lo}, 64'h00000000_FFFFFFFE);
        req(OP_MTLO, 1'b0, 32'hFFFFFFFF, 32'h0);
        check("mtlo_hilo", {hi, lo}, 64'h00000000_FFFFFFFF);
        req(OP_MADD, 1'b0, 32'h1, 32'h1);
        wait_idle(c);
        check("madd_hilo", {hi, lo}, 64'h00000001_00000000);
        req(OP_MSUB, 1'b0, 32'h1, 32'h1);
        wait_idle(c);
        check("msub1_hilo", {hi, lo}, 64'h00000000_FFFFFFFF);
        req(OP_MSUB, 1'b0, 32'h1, 32'h1);
        wait_idle(c);
        check("msub2_hilo", {hi, lo}, 64'h00000000_FFFFFFFE);
        req(OP_MTHI, 1'b0, 32'h0, 32'h0);
        req(OP_MTLO, 1'b0, 32'h0, 32'h0);
        req(OP_MSUB, 1'b0, 32'h1, 32'h1);
        wait_idle(c);
        check("msub_wrap_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
        req(OP_MADD, 1'b1, 32'hFFFFFFFF, 32'h1);
        wait_idle(c);
        check("smadd_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);

        req(3'd0, 1'b0, 32'h1234, 32'h5678);
        check("ill0_busy", busy, 0);
        check("ill0_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
        req(3'd7, 1'b1, 32'h1234, 32'h5678);
        check("ill7_busy", busy, 0);
        check("ill7_in_valid", mul_in_valid, 0);
        check("ill7_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);

        @(negedge clock);
        spurious = 1'b1;
        @(negedge clock);
        spurious = 1'b0;
        check("spurious_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
        check("spurious_busy", busy, 0);

        in_rdy_en = 1'b0;
        req(OP_MULT, 1'b0, 32'd7, 32'd9);
        req_valid = 1'b1;
        req_op    = OP_MTHI;
        req_src0  = 32'h1234;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_valid", mul_in_valid, 1);
            check("bp_src0", mul_in_src0, 7);
            check("bp_src1", mul_in_src1, 9);
            check("bp_ready", req_ready, 0);
            check("bp_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
            @(negedge clock);
        end
        req_valid = 1'b0;
        in_rdy_en = 1'b1;
        @(negedge clock);
        check("bp_wait_busy", busy, 1);
        check("bp_wait_ready", mul_out_ready, 1);
        @(negedge clock);
        check("bp_done_busy", busy, 0);
        check("bp_hilo_done", {hi, lo}, 64'h00000000_0000003F);

        req(OP_MULT, 1'b0, 32'd2, 32'd3);
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = OP_MTLO;
        req_src0  = 32'h55;
        check("same_cyc_ready_wait", req_ready, 0);
        @(negedge clock);
        check("same_cyc_lo_result", lo, 6);
        check("same_cyc_ready_idle", req_ready, 1);
        @(negedge clock);
        req_valid = 1'b0;
        check("same_cyc_mtlo", {hi, lo}, 64'h00000000_00000055);

        out_delay = 3;
        req(OP_MULT, 1'b0, 32'd3, 32'd4);
        @(negedge clock);
        check("rstw_in_wait", mul_out_ready, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rstw_busy", busy, 0);
        check("rstw_ready", req_ready, 1);
        check("rstw_out_ready", mul_out_ready, 0);
        check("rstw_hilo", {hi, lo}, 64'h0);
        repeat (4) @(negedge clock);
        check("rstw_no_write", {hi, lo}, 64'h0);
        out_delay = 0;
        req(OP_MULT, 1'b0, 32'd5, 32'd6);
        wait_idle(c);
        check("rstw_new_cycles", c, 2);
        check("rstw_new_hilo", {hi, lo}, 64'd30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
